// File: rtl/puf_chal_driver_if.sv
// rtl/puf_chal_driver_if.sv - host-side request/result bundle for puf_chal_driver
//
// Purpose: groups the host handshake (start + operands) and the result
// (busy/done/resp/ones) of the PUF challenge driver.
// Signals:
//   start   host -> driver  single-cycle request
//   chal    host -> driver  CHAL_W-bit challenge
//   sel     host -> driver  PUF instance select
//   len     host -> driver  delay-length select
//   n_eval  host -> driver  evaluation count (0 means 1)
//   busy    driver -> host  operation in progress
//   done    driver -> host  one-cycle result-valid pulse
//   resp    driver -> host  majority-voted response bit
//   ones    driver -> host  number of sampled 1s
interface puf_chal_driver_if #(
  parameter int CHAL_W = 128,
  parameter int EVAL_W = 8
);
  logic              start;
  logic [CHAL_W-1:0] chal;
  logic [1:0]        sel;
  logic [1:0]        len;
  logic [EVAL_W-1:0] n_eval;
  logic              busy;
  logic              done;
  logic              resp;
  logic [EVAL_W-1:0] ones;

  modport master (
    output start, chal, sel, len, n_eval,
    input  busy, done, resp, ones
  );

  modport slave (
    input  start, chal, sel, len, n_eval,
    output busy, done, resp, ones
  );
endinterface

// File: rtl/puf_chal_driver.sv
// rtl/puf_chal_driver.sv - serial challenge loader and majority-voting arbiter evaluator
//
// Purpose: latches a parallel challenge, shifts it MSB first into the PUF
// macro's challenge chain with a generated clk/2 shift clock, then runs N
// arbiter evaluations (reset hold, release, settle, sample) and majority-votes
// the synchronized response bits.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   host       request/result bundle (slave side), see puf_chal_driver_if
//   puf_clk    shift-chain clock, high in the second phase of each bit
//   puf_si     shift-chain serial data, set in the first phase of each bit
//   puf_rstn   shift-chain reset, active-low, pulsed before shifting
//   puf_reset  arbiter reset, active-high, low only while settling
//   puf_sel    registered PUF instance select
//   puf_len    registered delay-length select
//   puf_out    asynchronous arbiter response
module puf_chal_driver #(
  parameter int CHAL_W     = 128,
  parameter int RST_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int EVAL_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  puf_chal_driver_if.slave      host,
  output logic                  puf_clk,
  output logic                  puf_si,
  output logic                  puf_rstn,
  output logic                  puf_reset,
  output logic [1:0]            puf_sel,
  output logic [1:0]            puf_len,
  input  logic                  puf_out
);

  localparam int SHIFT_CYC = 2 * CHAL_W;
  localparam int MAX_A     = (SHIFT_CYC > RST_CYC) ? SHIFT_CYC : RST_CYC;
  localparam int CNT_MAX   = (MAX_A > SETTLE_CYC) ? MAX_A : SETTLE_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [EVAL_W-1:0] N_ONE   = EVAL_W'(1);
  localparam logic [EVAL_W:0]   E_ONE   = (EVAL_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SHIFT,
    S_ARM,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [CHAL_W-1:0] chal_sr;
  logic [EVAL_W-1:0] n_eff;
  logic [EVAL_W-1:0] eval_cnt;
  logic              sync1, sync2;

  logic [EVAL_W:0]   eval_next;
  logic              last_eval;
  logic [EVAL_W-1:0] ones_inc;
  logic              resp_d;

  logic busy_d, done_d, puf_clk_d, puf_si_d, puf_rstn_d, puf_reset_d;

  assign eval_next = {1'b0, eval_cnt} + E_ONE;
  assign last_eval = (eval_next >= {1'b0, n_eff});
  // Saturating add: the count can only reach the ceiling when N is the
  // maximum and every sample is 1, but it must never wrap.
  assign ones_inc  = (host.ones == '1) ? host.ones
                   : host.ones + {{(EVAL_W-1){1'b0}}, sync2};
  // Strict majority; a tie resolves to 0.
  assign resp_d    = ({ones_inc, 1'b0} > {1'b0, n_eff});

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state logic. cnt restarts at 0 on every state entry.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_ONE;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (host.start) state_n = S_CLR;
      end
      S_CLR: begin
        if (cnt == CNT_ONE) begin
          state_n = S_SHIFT;
          cnt_n   = '0;
        end
      end
      S_SHIFT: begin
        if (cnt == CNT_W'(SHIFT_CYC - 1)) begin
          state_n = S_ARM;
          cnt_n   = '0;
        end
      end
      S_ARM: begin
        if (cnt == CNT_W'(RST_CYC - 1)) begin
          state_n = S_SETTLE;
          cnt_n   = '0;
        end
      end
      S_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          state_n = S_SAMPLE;
          cnt_n   = '0;
        end
      end
      S_SAMPLE: begin
        cnt_n   = '0;
        state_n = last_eval ? S_DONE : S_ARM;
      end
      S_DONE: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // Output logic. Pin values are decoded from the upcoming state so that,
  // once registered, they line up exactly with the state they belong to.
  // In SHIFT, even cnt is phase A (data), odd cnt is phase B (clock high).
  always_comb begin
    busy_d      = !(state_n inside {S_IDLE, S_DONE});
    done_d      = (state_n == S_DONE);
    puf_rstn_d  = (state_n != S_CLR);
    puf_reset_d = (state_n != S_SETTLE);
    puf_clk_d   = (state_n == S_SHIFT) && cnt_n[0];
    puf_si_d    = 1'b0;
    if (state_n == S_SHIFT) begin
      // Data holds through phase B so it is stable across the rising edge.
      puf_si_d = cnt_n[0] ? puf_si : chal_sr[CHAL_W-1];
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host.busy <= 1'b0;
      host.done <= 1'b0;
      puf_clk   <= 1'b0;
      puf_si    <= 1'b0;
      puf_rstn  <= 1'b0;
      puf_reset <= 1'b1;
    end else begin
      host.busy <= busy_d;
      host.done <= done_d;
      puf_clk   <= puf_clk_d;
      puf_si    <= puf_si_d;
      puf_rstn  <= puf_rstn_d;
      puf_reset <= puf_reset_d;
    end
  end

  // Datapath: operand latch, challenge shifter, response synchronizer and
  // vote accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chal_sr   <= '0;
      n_eff     <= N_ONE;
      eval_cnt  <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      puf_sel   <= 2'b00;
      puf_len   <= 2'b00;
      host.ones <= '0;
      host.resp <= 1'b0;
    end else begin
      sync1 <= puf_out;
      sync2 <= sync1;
      case (state)
        S_IDLE: begin
          if (host.start) begin
            chal_sr   <= host.chal;
            puf_sel   <= host.sel;
            puf_len   <= host.len;
            n_eff     <= (host.n_eval == '0) ? N_ONE : host.n_eval;
            eval_cnt  <= '0;
            host.ones <= '0;
          end
        end
        S_SHIFT: begin
          // Advance after phase A so the next bit is at the MSB by the time
          // the following phase A is decoded.
          if (!cnt[0]) chal_sr <= {chal_sr[CHAL_W-2:0], 1'b0};
        end
        S_SAMPLE: begin
          host.ones <= ones_inc;
          eval_cnt  <= eval_next[EVAL_W-1:0];
          // resp keeps the previous result until the new vote is final.
          if (last_eval) host.resp <= resp_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/puf_chal_driver.md
Name: puf_chal_driver

Overview:
- Host-side initiator for the PUF macro's serial challenge / arbiter-response interface.
- Loads a parallel challenge and serializes it into the challenge shift chain with a generated shift clock, then selects a PUF instance and delay length.
- Runs N arbiter evaluations (reset hold, release, settle, sample) and majority-votes the sampled response bits into one response bit plus a ones-count.
- Sits between the host/register block and the PUF macro pins (clk/si/rstn/reset/puf_sel/length/out).

Parameters:
CHAL_W, 128, challenge length in bits; equals shift-chain length.
RST_CYC, 4, cycles puf_reset is held high before each evaluation; minimum 1.
SETTLE_CYC, 16, cycles from puf_reset release to sample; minimum 3, which covers the 2-flop synchronizer.
EVAL_W, 8, width of the evaluation-count input and the ones-count output.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; accepted only in IDLE
chal  input  CHAL_W  challenge; latched on accepted start
sel  input  2  PUF instance select; latched on accepted start
len  input  2  delay-length select; latched on accepted start
n_eval  input  EVAL_W  number of evaluations; latched on start; 0 is treated as 1
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse when the result is valid
resp  output  1  majority-voted response; held until the next accepted start
ones  output  EVAL_W  count of sampled 1s; held until the next accepted start
puf_clk  output  1  shift-chain clock (registered, clk/2 during SHIFT)
puf_si  output  1  shift-chain serial data
puf_rstn  output  1  shift-chain reset, active-low
puf_reset  output  1  arbiter reset to the macro, active-high; idle high
puf_sel  output  2  registered copy of the latched sel
puf_len  output  2  registered copy of the latched len
puf_out  input  1  asynchronous arbiter response; passes through a 2-flop synchronizer

Behaviour:
- Reset values:
  - busy, done, resp, puf_clk, puf_si: 0.
  - ones: 0.
  - puf_rstn: 0.
  - puf_reset: 1.
  - puf_sel, puf_len: 0.
  - FSM: IDLE.
- Reset asserted mid-operation aborts immediately to these values. No partial result is reported.
- All outputs are registered.
- IDLE:
  - puf_rstn=1, puf_reset=1, puf_clk=0.
  - On start=1: latch chal/sel/len/n_eval, clear ones, go to CLR.
- CLR (2 cycles): puf_rstn=0; then puf_rstn=1, go to SHIFT.
- SHIFT (2*CHAL_W cycles):
  - Bits go out MSB first, chal[CHAL_W-1] down to chal[0].
  - Each bit takes two phases:
    - Phase A: puf_si=bit, puf_clk=0.
    - Phase B: puf_clk=1, puf_si unchanged.
  - puf_si is stable across the puf_clk rising edge.
  - After the last phase B: puf_clk=0, go to ARM.
- ARM (RST_CYC cycles): puf_reset=1. Then go to SETTLE.
- SETTLE (SETTLE_CYC cycles): puf_reset=0, which launches the race.
- SAMPLE (1 cycle):
  - ones += synchronized puf_out.
  - puf_reset returns to 1.
  - Evaluation counter increments.
  - If the counter is below the effective N, go to ARM; otherwise go to DONE.
- DONE (1 cycle):
  - resp = (2*ones > N); a tie gives 0.
  - done=1, busy=0 in the same cycle; then IDLE.
- Latency: done is asserted exactly 2 + 2*CHAL_W + N*(RST_CYC+SETTLE_CYC+1) cycles after busy rises (defaults, N=1: 279 cycles).
- Busy handling:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - start in the cycle after DONE is accepted.
- puf_sel/puf_len change only on an accepted start. They are stable throughout SHIFT and all evaluations.
- ones saturates at 2^EVAL_W-1 (reachable only with N = 2^EVAL_W-1 and all ones); no wrap.
- Exactly CHAL_W puf_clk rising edges occur per operation. No puf_clk edges occur outside SHIFT.

Test Plan:
- Reset mid-SHIFT (after 40 bits) -> puf_rstn=0, puf_reset=1, busy=0, puf_clk=0 immediately. A new start after release runs the full 279-cycle sequence.
- chal=128'h8000...0001, n_eval=1, model chain -> exactly 128 puf_clk rises. The first bit is 1, bits 2-127 are 0, the last is 1. The model chain equals chal. done arrives at cycle 279 after busy.
- n_eval=3, puf_out tied 1 -> three puf_reset low windows of 16 cycles each. ones=3, resp=1, done at cycle 321.
- n_eval=4, puf_out sequence 1,0,1,0 (changed during ARM) -> ones=2, resp=0 (tie rule).
- n_eval=0 -> one evaluation. sel=2'b10, len=2'b11 -> puf_sel=10, puf_len=11 held through done. A start pulse mid-operation has no effect.
- Back-to-back: start in the cycle after done -> accepted. ones is cleared, then accumulates fresh; the prior resp holds until the new DONE.
